// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the parametrised single-clock FIFO.
//   FIFO_DATA_W : default data word width
//   FIFO_DEPTH  : default number of entries
//   ptr_w()     : pointer / occupancy width for a given depth (address bits
//                 plus one wrap bit)
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 8;

    // Address bits plus one wrap bit; also the width of the occupancy count,
    // which must be able to represent DEPTH itself.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage for the FIFO: one write port, one registered read
// port. The array itself carries no reset so it maps onto block RAM; only the
// read data register is cleared by reset.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (read data register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata updates on the next rising edge
//   raddr  in   read address
//   rdata  out  registered read data, holds when re is low
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with wrap-bit pointers, occupancy count,
// almost-full/almost-empty thresholds, overflow/underflow pulses and a
// synchronous flush.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   flush         in   synchronous clear of pointers, rvalid and error pulses
//   wen / wdata   in   write request and data
//   ren           in   read request
//   rdata         out  registered read data (holds when no read is accepted)
//   rvalid        out  rdata was updated by an accepted read at the last edge
//   full / empty  out  count == DEPTH / count == 0
//   almost_full   out  count >= AFULL_TH
//   almost_empty  out  count <= AEMPTY_TH
//   count         out  occupancy
//   overflow      out  one-cycle pulse after a wen while full
//   underflow     out  one-cycle pulse after a ren while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wen,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      ren,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW-1:0] AFULL_TH_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_TH_C = PW'(AEMPTY_TH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [PW-1:0] wptr_reg, wptr_next;
    logic [PW-1:0] rptr_reg, rptr_next;
    logic          rvalid_reg, rvalid_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_ok, rd_ok;
    logic          mem_we, mem_re;

    // Flags come straight from the registered pointers. Equal pointers mean
    // empty; equal addresses with differing wrap bits mean full.
    assign empty        = (wptr_reg == rptr_reg);
    assign full         = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) &&
                          (wptr_reg[AW] != rptr_reg[AW]);
    assign count        = wptr_reg - rptr_reg;
    assign almost_full  = (count >= AFULL_TH_C);
    assign almost_empty = (count <= AEMPTY_TH_C);

    // Acceptance uses the pre-edge flags, so a read frees no space for a
    // write in the same cycle, and a write cannot feed a read in the same
    // cycle.
    assign wr_ok  = wen && !full;
    assign rd_ok  = ren && !empty;
    assign mem_we = wr_ok && !flush;
    assign mem_re = rd_ok && !flush;

    always_comb begin
        wptr_next      = wptr_reg;
        rptr_next      = rptr_reg;
        rvalid_next    = 1'b0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_ok) begin
                wptr_next = wptr_reg + PW'(1);
            end
            if (rd_ok) begin
                rptr_next = rptr_reg + PW'(1);
            end
            rvalid_next    = rd_ok;
            overflow_next  = wen && full;
            underflow_next = ren && empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            rvalid_reg    <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            rvalid_reg    <= rvalid_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign rvalid    = rvalid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wptr_reg[AW-1:0]),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (rptr_reg[AW-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed stimulus with a read-data scoreboard. Instance A uses the default
// 16x8 configuration; instance B uses 32x4 with thresholds 3/1.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=16, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2
    logic        a_flush, a_wen, a_ren;
    logic [15:0] a_wdata, a_rdata;
    logic        a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
    logic [3:0]  a_count;

    // Instance B: DATA_W=32, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1
    logic        b_flush, b_wen, b_ren;
    logic [31:0] b_wdata, b_rdata;
    logic        b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
    logic [2:0]  b_count;

    sync_fifo_param #(
        .DATA_W (16),
        .DEPTH  (8)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (a_flush),
        .wen          (a_wen),
        .wdata        (a_wdata),
        .ren          (a_ren),
        .rdata        (a_rdata),
        .rvalid       (a_rvalid),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_afull),
        .almost_empty (a_aempty),
        .count        (a_count),
        .overflow     (a_ovf),
        .underflow    (a_udf)
    );

    sync_fifo_param #(
        .DATA_W    (32),
        .DEPTH     (4),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (b_flush),
        .wen          (b_wen),
        .wdata        (b_wdata),
        .ren          (b_ren),
        .rdata        (b_rdata),
        .rvalid       (b_rvalid),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_afull),
        .almost_empty (b_aempty),
        .count        (b_count),
        .overflow     (b_ovf),
        .underflow    (b_udf)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_a_q [$];
    logic [31:0] exp_b_q [$];
    logic [31:0] e_a, e_b;

    logic [31:0] b_pat [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every rvalid pops one expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rvalid) begin
                if (exp_a_q.size() == 0) begin
                    check("a_rvalid_unexpected", 32'(a_rvalid), 32'(0));
                end else begin
                    e_a = exp_a_q.pop_front();
                    $display("txn a read rdata=0x%0h expected=0x%0h", a_rdata, e_a);
                    check("a_rdata", 32'(a_rdata), e_a);
                end
            end
            if (b_rvalid) begin
                if (exp_b_q.size() == 0) begin
                    check("b_rvalid_unexpected", 32'(b_rvalid), 32'(0));
                end else begin
                    e_b = exp_b_q.pop_front();
                    $display("txn b read rdata=0x%0h expected=0x%0h", b_rdata, e_b);
                    check("b_rdata", b_rdata, e_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_flush = 1'b0; a_wen = 1'b0; a_ren = 1'b0; a_wdata = '0;
        b_flush = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        check("rst_a_count",  32'(a_count),  32'(0));
        check("rst_a_empty",  32'(a_empty),  32'(1));
        check("rst_a_aempty", 32'(a_aempty), 32'(1));
        check("rst_a_full",   32'(a_full),   32'(0));
        check("rst_a_afull",  32'(a_afull),  32'(0));
        check("rst_a_rdata",  32'(a_rdata),  32'(0));
        check("rst_a_rvalid", 32'(a_rvalid), 32'(0));
        check("rst_a_ovf",    32'(a_ovf),    32'(0));
        check("rst_a_udf",    32'(a_udf),    32'(0));
        check("rst_b_count",  32'(b_count),  32'(0));
        check("rst_b_empty",  32'(b_empty),  32'(1));
        rst_n = 1'b1;
        tick();

        // ---------------- fill A ----------------
        for (int i = 0; i < 8; i++) begin
            a_wen = 1'b1; a_wdata = 16'(32'h1000 + i);
            tick();
            $display("txn a write wdata=0x%0h count=%0d", a_wdata, a_count);
            check("fill_count", 32'(a_count), 32'(i + 1));
            check("fill_afull", 32'(a_afull), 32'(i + 1 >= 6));
            check("fill_full",  32'(a_full),  32'(i + 1 == 8));
        end
        a_wdata = 16'h1008;
        tick();
        check("fill_overflow",       32'(a_ovf),   32'(1));
        check("fill_overflow_count", 32'(a_count), 32'(8));
        a_wen = 1'b0;
        tick();
        check("overflow_not_sticky", 32'(a_ovf), 32'(0));

        // ---------------- drain A ----------------
        for (int i = 0; i < 8; i++) begin
            a_ren = 1'b1;
            exp_a_q.push_back(32'h1000 + i);
            tick();
            check("drain_count", 32'(a_count), 32'(7 - i));
        end
        check("drain_empty", 32'(a_empty), 32'(1));
        tick();
        check("drain_underflow",   32'(a_udf),    32'(1));
        check("drain_udf_rvalid",  32'(a_rvalid), 32'(0));
        check("drain_rdata_holds", 32'(a_rdata),  32'(16'h1007));
        a_ren = 1'b0;
        tick();
        check("underflow_not_sticky", 32'(a_udf), 32'(0));

        // ---------------- simultaneous when full ----------------
        for (int i = 0; i < 8; i++) begin
            a_wen = 1'b1; a_wdata = 16'(32'h2000 + i);
            tick();
        end
        check("sim_full_pre", 32'(a_full), 32'(1));
        a_ren = 1'b1; a_wdata = 16'hBEEF;
        exp_a_q.push_back(32'h2000);
        tick();
        check("sim_full_ovf",   32'(a_ovf),   32'(1));
        check("sim_full_count", 32'(a_count), 32'(7));
        a_wen = 1'b0;
        for (int i = 1; i < 8; i++) begin
            exp_a_q.push_back(32'h2000 + i);
            tick();
        end
        check("sim_full_drained", 32'(a_empty), 32'(1));

        // ---------------- simultaneous when empty ----------------
        a_wen = 1'b1; a_ren = 1'b1; a_wdata = 16'hCAFE;
        tick();
        check("sim_empty_count",  32'(a_count),  32'(1));
        check("sim_empty_udf",    32'(a_udf),    32'(1));
        check("sim_empty_rvalid", 32'(a_rvalid), 32'(0));
        a_wen = 1'b0;
        exp_a_q.push_back(32'hCAFE);
        tick();
        check("sim_empty_readback_count", 32'(a_count), 32'(0));
        a_ren = 1'b0;
        tick();

        // ---------------- wrap-around at count=3 ----------------
        for (int i = 0; i < 3; i++) begin
            a_wen = 1'b1; a_wdata = 16'(32'h3000 + i);
            tick();
        end
        check("wrap_start_count", 32'(a_count), 32'(3));
        for (int i = 0; i < 40; i++) begin
            a_wen = 1'b1; a_ren = 1'b1; a_wdata = 16'(32'h3003 + i);
            exp_a_q.push_back(32'h3000 + i);
            tick();
            check("wrap_count", 32'(a_count), 32'(3));
            check("wrap_ovf",   32'(a_ovf),   32'(0));
            check("wrap_udf",   32'(a_udf),   32'(0));
        end
        a_wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_a_q.push_back(32'h3028 + i);
            tick();
        end
        a_ren = 1'b0;
        tick();
        check("wrap_end_empty", 32'(a_empty), 32'(1));

        // ---------------- flush with wen ----------------
        for (int i = 0; i < 5; i++) begin
            a_wen = 1'b1; a_wdata = 16'(32'h4000 + i);
            tick();
        end
        check("flush_pre_count", 32'(a_count), 32'(5));
        a_flush = 1'b1; a_wdata = 16'h4444;
        tick();
        check("flush_count",       32'(a_count), 32'(0));
        check("flush_empty",       32'(a_empty), 32'(1));
        check("flush_rdata_holds", 32'(a_rdata), 32'(16'h302A));
        a_flush = 1'b0; a_wdata = 16'h5000;
        tick();
        check("post_flush_count", 32'(a_count), 32'(1));
        a_wen = 1'b0; a_ren = 1'b1;
        exp_a_q.push_back(32'h5000);
        tick();
        a_ren = 1'b0;
        tick();

        // ---------------- asynchronous reset mid-burst ----------------
        for (int i = 0; i < 4; i++) begin
            a_wen = 1'b1; a_wdata = 16'(32'h6000 + i);
            tick();
        end
        a_ren = 1'b1; a_wdata = 16'h6004;
        exp_a_q.push_back(32'h6000);
        @(posedge clk);
        #7;
        check("midburst_pre_rvalid", 32'(a_rvalid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata",  32'(a_rdata),  32'(0));
        check("async_rst_rvalid", 32'(a_rvalid), 32'(0));
        check("async_rst_count",  32'(a_count),  32'(0));
        check("async_rst_empty",  32'(a_empty),  32'(1));
        a_wen = 1'b0; a_ren = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(a_count), 32'(0));

        // ---------------- instance B: 32x4 ----------------
        for (int i = 0; i < 4; i++) begin
            b_wen = 1'b1; b_wdata = b_pat[i];
            tick();
            $display("txn b write wdata=0x%0h count=%0d", b_wdata, b_count);
            check("b_count",  32'(b_count),  32'(i + 1));
            check("b_full",   32'(b_full),   32'(i + 1 == 4));
            check("b_afull",  32'(b_afull),  32'(i + 1 >= 3));
            check("b_aempty", 32'(b_aempty), 32'(i + 1 <= 1));
        end
        b_wdata = 32'h55555555;
        tick();
        check("b_overflow",       32'(b_ovf),   32'(1));
        check("b_overflow_count", 32'(b_count), 32'(4));
        b_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_ren = 1'b1;
            exp_b_q.push_back(b_pat[i]);
            tick();
        end
        check("b_drain_empty", 32'(b_empty), 32'(1));
        b_ren = 1'b0;
        tick();
        tick();

        check("a_scoreboard_drained", 32'(exp_a_q.size()), 32'(0));
        check("b_scoreboard_drained", 32'(exp_b_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
